// File: rtl/avalon_pio_in_irq.sv
// avalon_pio_in_irq
//   Avalon-MM input PIO. Each in_port bit passes through a synchroniser. The resulting value feeds
//   an edge detector and a write-1-to-clear edge-capture register. The captured bits are masked
//   per bit and combined into a level interrupt for the Nios II.
//   Register map (word address):
//     0 data (read-only)
//     1 direction (reads 0)
//     2 irqmask
//     3 edgecapture (write 1 to clear)
//   Optional feature: define PIO_IN_DEBOUNCE_EN to add a per-bit debouncer between the
//   synchroniser and the value register.
module avalon_pio_in_irq #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter logic [31:0] RESET_MASK      = '0,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_DIR  = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // Edge detection stays disabled until the sync chain, and the debouncer if present, hold real
   // samples. Without this hold-off, an input already high at reset release would look like a
   // rising edge as it ripples through the zeroed pipeline.
`ifdef PIO_IN_DEBOUNCE_EN
   localparam int unsigned PRIME_CYCLES = SYNC_STAGES + 1;
`else
   localparam int unsigned PRIME_CYCLES = SYNC_STAGES;
`endif

   // Reject out-of-range parameters at elaboration.
   if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || EDGE_TYPE > 2 ||
       DEBOUNCE_CYCLES < 1) begin : g_param_check
      $error("avalon_pio_in_irq: parameter out of range");
   end

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [2:0]                        prime_cnt_q, prime_cnt_d;
   logic                              primed_q, primed_d;
   logic [WIDTH-1:0]                  prev_q, prev_d;
   logic [WIDTH-1:0]                  edgecap_q, edgecap_d;
   logic [WIDTH-1:0]                  irqmask_q, irqmask_d;
   logic [31:0]                       readdata_q, readdata_d;
   logic [WIDTH-1:0]                  sync_s;
   logic [WIDTH-1:0]                  val;
   logic [WIDTH-1:0]                  edge_raw;
   logic [WIDTH-1:0]                  clr;
   logic                              wr_en;
   logic                              unused_wdata;

   assign sync_s = sync_q[SYNC_STAGES-1];
   assign wr_en  = chipselect & ~write_n;

   // Only writedata[WIDTH-1:0] is meaningful; the upper bits are intentionally ignored.
   assign unused_wdata = ^writedata;

   // Synchroniser shift and reset-release priming counter.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      sync_d      = sync_q;
      prime_cnt_d = prime_cnt_q;
      sync_d[0]   = in_port;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
         sync_d[k] = sync_q[k-1];
      end
      primed_d = primed_q | (prime_cnt_q == 3'(PRIME_CYCLES));
      if (!primed_q && (prime_cnt_q != 3'(PRIME_CYCLES))) begin
         prime_cnt_d = prime_cnt_q + 3'd1;
      end
   end

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int unsigned DB_CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [WIDTH-1:0][DB_CW-1:0] db_cnt_q, db_cnt_d;
   logic [WIDTH-1:0]            val_q, val_d;

   // Debounce: the value toggles only after the input has disagreed with it for
   // DEBOUNCE_CYCLES consecutive clocks. The value is seeded directly while priming.
   always_comb begin
      db_cnt_d = db_cnt_q;
      val_d    = val_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (!primed_q) begin
            val_d[i]    = sync_s[i];
            db_cnt_d[i] = '0;
         end else if (sync_s[i] == val_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_CW'(DEBOUNCE_CYCLES - 1)) begin
            val_d[i]    = ~val_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DB_CW'(1);
         end
      end
   end

   // Debouncer state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt_q <= '0;
         val_q    <= '0;
      end else begin
         db_cnt_q <= db_cnt_d;
         val_q    <= val_d;
      end
   end

   assign val = val_q;
`else
   assign val = sync_s;
`endif

   // Edge detection, edge capture with write-1-to-clear, mask write and read mux.
   always_comb begin
      case (EDGE_TYPE)
         0:       edge_raw = val & ~prev_q;
         1:       edge_raw = ~val & prev_q;
         default: edge_raw = val ^ prev_q;
      endcase
      prev_d = val;

      clr = '0;
      if (wr_en && (address == ADDR_EDGE)) begin
         clr = writedata[WIDTH-1:0];
      end
      // A new edge on a bit takes priority over a same-cycle clear of that bit.
      edgecap_d = (edge_raw & {WIDTH{primed_q}}) | (edgecap_q & ~clr);

      irqmask_d = irqmask_q;
      if (wr_en && (address == ADDR_MASK)) begin
         irqmask_d = writedata[WIDTH-1:0];
      end

      case (address)
         ADDR_DATA: readdata_d = 32'(val);
         ADDR_DIR:  readdata_d = '0;
         ADDR_MASK: readdata_d = 32'(irqmask_q);
         default:   readdata_d = 32'(edgecap_q);
      endcase
   end

   // State registers; reset discards any pending edges.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset_n) begin
         sync_q      <= '0;
         prime_cnt_q <= '0;
         primed_q    <= 1'b0;
         prev_q      <= '0;
         edgecap_q   <= '0;
         irqmask_q   <= RESET_MASK[WIDTH-1:0];
         readdata_q  <= '0;
      end else begin
         sync_q      <= sync_d;
         prime_cnt_q <= prime_cnt_d;
         primed_q    <= primed_d;
         prev_q      <= prev_d;
         edgecap_q   <= edgecap_d;
         irqmask_q   <= irqmask_d;
         readdata_q  <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// tb_avalon_pio_in_irq
//   Directed bench for avalon_pio_in_irq. Two instances share one Avalon bus:
//     dut_r uses rising-edge capture with RESET_MASK = 0x05.
//     dut_a uses any-edge capture.
//   The debounce scenario runs only when PIO_IN_DEBOUNCE_EN is defined.
module tb_avalon_pio_in_irq;

   localparam int unsigned SYNC = 2;
`ifdef PIO_IN_DEBOUNCE_EN
   localparam int unsigned LAT = SYNC + 16;
`else
   localparam int unsigned LAT = SYNC;
`endif

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_r, in_a;
   logic [31:0] readdata_r, readdata_a;
   logic        irq_r, irq_a;

   int n_checks = 0;
   int n_fail   = 0;

   avalon_pio_in_irq #(
      .WIDTH(8), .SYNC_STAGES(SYNC), .EDGE_TYPE(0), .RESET_MASK(32'h0000_0005),
      .DEBOUNCE_CYCLES(16)
   ) dut_r (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_r), .readdata(readdata_r),
      .irq(irq_r)
   );

   avalon_pio_in_irq #(
      .WIDTH(8), .SYNC_STAGES(SYNC), .EDGE_TYPE(2), .RESET_MASK(32'h0),
      .DEBOUNCE_CYCLES(16)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_a), .readdata(readdata_a),
      .irq(irq_a)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Read: present the address at a negedge; readdata is valid at the following negedge.
   task automatic rd(input logic [1:0] a);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      @(negedge clk);
   endtask

   // Write: strobe for one clock, returning at the negedge after the write edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_r       = 8'hFF;
      in_a       = 8'h00;

      // 1: reset state; in_r held high across release must not produce an edge.
      repeat (3) @(negedge clk);
      check("rst_readdata_r", readdata_r, 32'h0);
      check("rst_irq_r", 32'(irq_r), 32'h0);
      check("rst_readdata_a", readdata_a, 32'h0);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      rd(2'd2);
      check("t1_mask_r", readdata_r, 32'h0000_0005);
      check("t1_mask_a", readdata_a, 32'h0);
      rd(2'd3);
      check("t1_ec_r_no_false_edge", readdata_r, 32'h0);
      rd(2'd0);
      check("t1_data_r", readdata_r, 32'h0000_00FF);
      check("t1_irq_r", 32'(irq_r), 32'h0);
      in_r = 8'h00;
      repeat (LAT + 4) @(negedge clk);
      rd(2'd3);
      check("t1_fall_ignored_ec_r", readdata_r, 32'h0);
      check("t1_fall_ignored_irq_r", 32'(irq_r), 32'h0);

      // 2: rising edge on bit0 with mask 0x01; exact capture latency, then fall ignored.
      wr(2'd2, 32'h0000_0001);
      address = 2'd0;
      in_r    = 8'h01;
      repeat (LAT) @(negedge clk);
      check("t2_data_before", readdata_r, 32'h0);
      check("t2_irq_before", 32'(irq_r), 32'h0);
      @(negedge clk);
      check("t2_data_after", readdata_r, 32'h0000_0001);
      check("t2_irq_after", 32'(irq_r), 32'h1);
      rd(2'd3);
      check("t2_ec", readdata_r, 32'h0000_0001);
      in_r = 8'h00;
      repeat (LAT + 3) @(negedge clk);
      rd(2'd3);
      check("t2_fall_ec", readdata_r, 32'h0000_0001);
      check("t2_fall_irq", 32'(irq_r), 32'h1);

      // 3: clear in the same cycle as a new rising edge (set wins), then a plain clear.
      address = 2'd0;
      in_r    = 8'h01;
      repeat (LAT) @(negedge clk);
      wr(2'd3, 32'h0000_0001);
      check("t3_setwins_irq", 32'(irq_r), 32'h1);
      rd(2'd3);
      check("t3_setwins_ec", readdata_r, 32'h0000_0001);
      wr(2'd3, 32'h0000_0001);
      check("t3_clear_irq", 32'(irq_r), 32'h0);
      rd(2'd3);
      check("t3_clear_ec", readdata_r, 32'h0);

      // 4: edge on an unmasked bit, then unmask it; upper writedata bits ignored.
      in_r = 8'h09;
      repeat (LAT + 2) @(negedge clk);
      rd(2'd3);
      check("t4_ec_bit3", readdata_r, 32'h0000_0008);
      check("t4_irq_masked", 32'(irq_r), 32'h0);
      wr(2'd2, 32'hFFFF_FF08);
      check("t4_irq_unmasked", 32'(irq_r), 32'h1);
      rd(2'd2);
      check("t4_mask_readback", readdata_r, 32'h0000_0008);

      // Direction reads 0 and ignores writes; data register ignores writes.
      wr(2'd1, 32'hFFFF_FFFF);
      rd(2'd1);
      check("dir_r", readdata_r, 32'h0);
      check("dir_a", readdata_a, 32'h0);
      wr(2'd0, 32'h0000_0000);
      rd(2'd0);
      check("data_after_write", readdata_r, 32'h0000_0009);

      // 5: any-edge capture on dut_a bit5, both directions; full-word compares cover [31:8].
      wr(2'd3, 32'h0000_00FF);
      in_a = 8'h20;
      repeat (LAT + 2) @(negedge clk);
      rd(2'd3);
      check("t5_rise_ec_a", readdata_a, 32'h0000_0020);
      wr(2'd3, 32'h0000_0020);
      rd(2'd3);
      check("t5_cleared_ec_a", readdata_a, 32'h0);
      in_a = 8'h00;
      repeat (LAT + 2) @(negedge clk);
      rd(2'd3);
      check("t5_fall_ec_a", readdata_a, 32'h0000_0020);
      rd(2'd0);
      check("t5_data_a", readdata_a, 32'h0);

`ifdef PIO_IN_DEBOUNCE_EN
      // 6: a 10-clock glitch is filtered; a long pulse shows up after SYNC+16 clocks.
      wr(2'd3, 32'h0000_00FF);
      wr(2'd2, 32'h0000_0080);
      address = 2'd0;
      in_r    = 8'h89;
      repeat (10) @(negedge clk);
      in_r = 8'h09;
      repeat (30) @(negedge clk);
      check("t6_glitch_data", readdata_r, 32'h0000_0009);
      rd(2'd3);
      check("t6_glitch_ec", readdata_r, 32'h0);
      check("t6_glitch_irq", 32'(irq_r), 32'h0);
      address = 2'd0;
      in_r    = 8'h89;
      repeat (LAT) @(negedge clk);
      check("t6_data_before", readdata_r, 32'h0000_0009);
      check("t6_irq_before", 32'(irq_r), 32'h0);
      @(negedge clk);
      check("t6_data_after", readdata_r, 32'h0000_0089);
      check("t6_irq_after", 32'(irq_r), 32'h1);
      repeat (40) @(negedge clk);
      in_r = 8'h09;
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
